regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter and sequencer for the register-file write port. Four requesters (e.g. ALU writeback, load return, multiplier, CSR/move unit) compete for the single write port; the block picks one per cycle, registers its address and data, and drives the 5:32 write-enable decoder through `select_bits`/`enabled`. It sits between the writeback-stage producers and the register file.

## Interface

Parameters:
- `DATA_W`, default 32: register data width.

Ports:
- `clk`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Asynchronous, active-high.
- `req`: input, 4 bits. Request per requester; bit i belongs to requester i.
- `req_addr`: input, 20 bits. Destination register, packed; requester i uses `[5i+4:5i]`.
- `req_data`: input, 4×`DATA_W` bits. Write data, packed; requester i uses `[DATA_W*i +: DATA_W]`.
- `stall`: input, 1 bit. Pipeline hold; no new grant is issued while it is high.
- `gnt`: output, 4 bits. One-hot acknowledge, high for exactly one cycle.
- `select_bits`: output, 5 bits. Register address to the 5:32 decoder.
- `enabled`: output, 1 bit. Decoder enable (register-file write strobe).
- `wr_data`: output, `DATA_W` bits. Data to the register-file write port.

## Operation

- FSM states:
  - IDLE: no write this cycle.
  - WRITE: one write issued this cycle.
- Eligible set: `elig = req & ~gnt & {4{~stall}}`, evaluated at each rising edge.
- Transitions, from either state:
  - `elig != 0` → WRITE.
  - Otherwise → IDLE.
- Winner: the first set bit of `elig` scanning from `ptr` upward, modulo 4.
- On a WRITE entry with winner w:
  - `gnt <= 1<<w`
  - `select_bits <= req_addr[w]`
  - `wr_data <= req_data[w]`
  - `enabled <= 1`
  - `ptr <= (w+1) mod 4`
- On an IDLE entry:
  - `gnt <= 0`
  - `enabled <= 0`
  - `select_bits` and `wr_data` hold their last values.
- Requester handshake:
  - Hold `req`, address and data stable until `gnt[i]` is seen high.
  - Either deassert `req` during that cycle, or present the next write.
- The `~gnt` mask prevents double-granting the same transaction. A requester therefore gets at most one grant every 2 cycles; the port itself can take one write per cycle across requesters.
- `stall` high: the next cycle is IDLE. `ptr` is unchanged and pending requests keep waiting.
- Outputs of different requesters never mix: `select_bits`, `wr_data` and `gnt` always come from the same winner.

## Timing

- Reset (asynchronous, immediate) sets: `gnt=0`, `enabled=0`, `select_bits=0`, `wr_data=0`, `ptr=0`, state IDLE.
- Latency: `req` sampled at edge N produces `gnt`, `select_bits`, `wr_data` and `enabled` valid from edge N to edge N+1. The register file captures the write at edge N+1.
- `enabled` is high for exactly the cycles the FSM is in WRITE.
- Wrap-around: a grant to requester 3 sets `ptr=0`.
- Simultaneous `req` and `stall`: `stall` wins; no grant is issued.
- Reset during WRITE: the write is dropped and `gnt` clears at once. The requester still holds `req` and is re-granted after reset, with `ptr=0`.
- Starvation bound: a continuously requesting, unstalled requester is granted within 4 WRITE cycles.

## Configuration

- `REGARB_R0_FILTER_EN`:
  - Defined: a winner whose address is `5'd0` still receives `gnt` and advances `ptr`, but `enabled` stays 0 for that cycle. `select_bits` and `wr_data` update as normal. The write is acknowledged and discarded, keeping r0 hard-wired zero.
  - Undefined: address 0 is written like any other register.

## Test plan

- Reset held, `req=4'b1111` → `gnt=0`, `enabled=0`, `select_bits=0`. After release, the first grant is `gnt=4'b0001`.
- All four requesting continuously (requester i re-requests the cycle after its grant) → grant sequence 0001, 0010, 0100, 1000, 0001, with `enabled=1` in every cycle.
- Only requester 2 requests, `req_addr[2]=5'd17`, `req_data[2]=32'hDEADBEEF` → one cycle later `gnt=4'b0100`, `select_bits=17`, `wr_data=DEADBEEF`, `enabled=1`. With req held, the next cycle is IDLE and the following one is WRITE again.
- `stall=1` for 3 cycles while `req=4'b0011` → `enabled=0` and `gnt=0` for those 3 cycles. After release, `gnt=4'b0001` then `4'b0010`.
- Async reset pulsed mid-cycle during a WRITE to address 9 → `enabled` and `gnt` drop before the next edge. The requester is re-granted after release, with `select_bits=9`.
- `req_addr[1]=0`, `req[1]=1`:
  - With `REGARB_R0_FILTER_EN` defined → `gnt=4'b0010`, `enabled=0`.
  - Without it → `enabled=1`, `select_bits=0`.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - requester/write-port bundle for the register-file write arbiter
//
// Purpose: groups the four-requester request bus and the register-file write
// port into one interface.
//   master : requester side (drives req, req_addr, req_data, stall)
//   slave  : arbiter side   (drives gnt, select_bits, enabled, wr_data)
// Ports (signals):
//   req[3:0]            request per requester
//   req_addr[19:0]      packed 5-bit destination per requester, [5i+4:5i]
//   req_data[4*DATA_W]  packed write data per requester, [DATA_W*i +: DATA_W]
//   stall               pipeline hold, blocks new grants
//   gnt[3:0]            one-hot acknowledge
//   select_bits[4:0]    register address to the 5:32 decoder
//   enabled             decoder enable / register-file write strobe
//   wr_data[DATA_W]     data to the register-file write port
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [3:0]          req;
  logic [19:0]         req_addr;
  logic [4*DATA_W-1:0] req_data;
  logic                stall;
  logic [3:0]          gnt;
  logic [4:0]          select_bits;
  logic                enabled;
  logic [DATA_W-1:0]   wr_data;

  modport master (
    output req, req_addr, req_data, stall,
    input  gnt, select_bits, enabled, wr_data
  );

  modport slave (
    input  req, req_addr, req_data, stall,
    output gnt, select_bits, enabled, wr_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter and sequencer for the register-file write port
//
// Purpose: picks one of four writeback requesters per cycle, registers its
// address and data, and drives the register-file write strobe.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    regfile_write_arbiter_if.slave (req/req_addr/req_data/stall in,
//          gnt/select_bits/enabled/wr_data out, all outputs registered)
// Build option:
//   REGARB_R0_FILTER_EN  when defined, a winner addressing r0 is granted and
//                        advances the pointer but does not raise enabled.
module regfile_write_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t            state;
  logic [1:0]        ptr;
  logic [3:0]        gnt_q;
  logic [4:0]        sel_q;
  logic [DATA_W-1:0] data_q;
  logic              en_q;

  logic [3:0]        elig;
  logic              found;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic [4:0]        win_addr;
  logic [DATA_W-1:0] win_data;

  // A requester just granted still shows req this cycle for the same
  // transaction; masking with the current grant prevents granting it twice.
  assign elig = bus.req & ~gnt_q & {4{~bus.stall}};

  // Rotating priority: first eligible requester at or after ptr, mod 4.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_addr = bus.req_addr[win*5 +: 5];
  assign win_data = bus.req_data[win*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      gnt_q  <= 4'b0000;
      sel_q  <= 5'd0;
      data_q <= '0;
      en_q   <= 1'b0;
    end else if (found) begin
      state  <= WRITE;
      gnt_q  <= 4'b0001 << win;
      sel_q  <= win_addr;
      data_q <= win_data;
      ptr    <= win + 2'd1;
`ifdef REGARB_R0_FILTER_EN
      // r0 is hard-wired zero: acknowledge the write but never strobe it.
      en_q   <= (win_addr != 5'd0);
`else
      en_q   <= 1'b1;
`endif
    end else begin
      // Address and data hold their last values while idle.
      state  <= IDLE;
      gnt_q  <= 4'b0000;
      en_q   <= 1'b0;
    end
  end

  // gnt_q is only nonzero in WRITE; gating by state keeps that structural.
  assign bus.gnt         = (state == WRITE) ? gnt_q : 4'b0000;
  assign bus.select_bits = sel_q;
  assign bus.wr_data     = data_q;
  assign bus.enabled     = en_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  localparam int DW = 32;

  logic clk;
  logic reset;

  regfile_write_arbiter_if #(.DATA_W(DW)) bus ();

  regfile_write_arbiter #(.DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_on      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rotating priority over requesters that ask, are not
  // holding a grant right now, and are not blocked by stall.
  function automatic int pick(input logic [3:0] e, input int p);
    for (int o = 0; o < 4; o++) begin
      int c = (p + o) % 4;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  logic [3:0]    m_gnt;
  logic [4:0]    m_sel;
  logic [DW-1:0] m_data;
  logic          m_en;
  int            m_ptr;
  int            m_w;

  always_comb m_w = pick(bus.req & ~m_gnt & (bus.stall ? 4'b0000 : 4'b1111), m_ptr);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_gnt  <= 4'b0000;
      m_sel  <= 5'd0;
      m_data <= '0;
      m_en   <= 1'b0;
      m_ptr  <= 0;
    end else if (m_w < 0) begin
      m_gnt <= 4'b0000;
      m_en  <= 1'b0;
    end else begin
      m_gnt  <= 4'(1 << m_w);
      m_sel  <= bus.req_addr[5*m_w +: 5];
      m_data <= bus.req_data[DW*m_w +: DW];
      m_ptr  <= (m_w + 1) % 4;
`ifdef REGARB_R0_FILTER_EN
      m_en   <= (bus.req_addr[5*m_w +: 5] != 5'd0);
`else
      m_en   <= 1'b1;
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_gnt", 32'(bus.gnt), 32'(m_gnt));
      chk("model_enabled", 32'(bus.enabled), 32'(m_en));
      chk("model_select_bits", 32'(bus.select_bits), 32'(m_sel));
      chk("model_wr_data", bus.wr_data, m_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    bus.req_addr[5*i +: 5] = a;
  endtask

  logic [3:0] rr_tbl [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [4:0] vec_req [12] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1010, 4'b1010,
                               4'b0101, 4'b0101, 4'b0101, 4'b1000, 4'b0000, 4'b1111};
  logic       vec_stall [12] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    reset     = 1'b1;
    bus.req   = 4'b1111;
    bus.stall = 1'b0;
    set_addr(0, 5'd3);
    set_addr(1, 5'd7);
    set_addr(2, 5'd17);
    set_addr(3, 5'd25);
    bus.req_data[0*DW +: DW] = 32'h1111_0000;
    bus.req_data[1*DW +: DW] = 32'h2222_0001;
    bus.req_data[2*DW +: DW] = 32'hDEAD_BEEF;
    bus.req_data[3*DW +: DW] = 32'h4444_0003;

    // Reset held with all requesting.
    cyc();
    cmp_on = 1'b1;
    cyc();
    mid();
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    chk("reset_enabled", 32'(bus.enabled), 32'h0);
    chk("reset_select_bits", 32'(bus.select_bits), 32'h0);
    reset = 1'b0;

    // Continuous requests rotate 0,1,2,3,0 with a write every cycle.
    for (int k = 0; k < 5; k++) begin
      cyc();
      mid();
      chk("rr_gnt", 32'(bus.gnt), 32'(rr_tbl[k]));
      chk("rr_enabled", 32'(bus.enabled), 32'h1);
    end

    // Lone requester 2: WRITE, IDLE, WRITE with req held.
    bus.req = 4'b0100;
    cyc();
    mid();
    chk("r2_gnt", 32'(bus.gnt), 32'h4);
    chk("r2_select_bits", 32'(bus.select_bits), 32'd17);
    chk("r2_wr_data", bus.wr_data, 32'hDEAD_BEEF);
    chk("r2_enabled", 32'(bus.enabled), 32'h1);
    cyc();
    mid();
    chk("r2_idle_enabled", 32'(bus.enabled), 32'h0);
    chk("r2_idle_gnt", 32'(bus.gnt), 32'h0);
    chk("r2_idle_hold_sel", 32'(bus.select_bits), 32'd17);
    cyc();
    mid();
    chk("r2_again_gnt", 32'(bus.gnt), 32'h4);

    // Stall for three cycles, then 0 then 1 (ptr wrapped to 0 after 2->3 ptr).
    bus.req   = 4'b0011;
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      mid();
      chk("stall_enabled", 32'(bus.enabled), 32'h0);
      chk("stall_gnt", 32'(bus.gnt), 32'h0);
    end
    bus.stall = 1'b0;
    cyc();
    mid();
    chk("unstall_gnt0", 32'(bus.gnt), 32'h1);
    cyc();
    mid();
    chk("unstall_gnt1", 32'(bus.gnt), 32'h2);

    // Asynchronous reset in the middle of a write to r9.
    bus.req = 4'b0001;
    set_addr(0, 5'd9);
    cyc();
    chk("pre_reset_gnt", 32'(bus.gnt), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_enabled", 32'(bus.enabled), 32'h0);
    chk("async_gnt", 32'(bus.gnt), 32'h0);
    mid();
    reset = 1'b0;
    cyc();
    mid();
    chk("regrant_gnt", 32'(bus.gnt), 32'h1);
    chk("regrant_select_bits", 32'(bus.select_bits), 32'd9);

    // Requester 1 targeting r0.
    set_addr(1, 5'd0);
    bus.req = 4'b0010;
    cyc();
    mid();
    chk("r0_gnt", 32'(bus.gnt), 32'h2);
    chk("r0_select_bits", 32'(bus.select_bits), 32'h0);
`ifdef REGARB_R0_FILTER_EN
    chk("r0_enabled", 32'(bus.enabled), 32'h0);
`else
    chk("r0_enabled", 32'(bus.enabled), 32'h1);
`endif
    bus.req = 4'b0000;
    cyc();

    // Mixed directed patterns, checked against the model each cycle.
    set_addr(1, 5'd7);
    for (int k = 0; k < 12; k++) begin
      bus.req   = vec_req[k][3:0];
      bus.stall = vec_stall[k];
      bus.req_data[(k%4)*DW +: DW] = 32'hA500_0000 + 32'(k);
      cyc();
    end
    bus.req   = 4'b0000;
    bus.stall = 1'b0;
    cyc();
    cyc();
    mid();

    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
